serial_adder: RTL



---
 rtl/serial_adder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder with valid/ready handshakes.
// Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first,
// reusing one DIGIT-wide adder slice over N = WIDTH/DIGIT cycles.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a-b (B latched inverted, initial carry forced to 1, cin ignored).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  // Parameter legality: DIGIT must divide WIDTH, WIDTH at least 2.
  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_adder: illegal parameters, need WIDTH >= 2 and DIGIT dividing WIDTH");
    end
  endgenerate

  localparam int N    = WIDTH / DIGIT;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int LAST = N - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One DIGIT-wide slice: {carry_out, digit_sum}.
  function automatic logic [DIGIT:0] slice_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // Carry entering the top bit of the slice, recovered from that bit's sum.
  function automatic logic msb_carry_in(input logic x_msb,
                                        input logic y_msb,
                                        input logic d_msb);
    return x_msb ^ y_msb ^ d_msb;
  endfunction

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             c_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic [DIGIT:0]   slice_s;
  logic [DIGIT-1:0] digit_s;
  logic             cy_s;
  logic             cmsb_s;
  logic [WIDTH-1:0] sum_nx_s;
  logic             last_s;

  // Operand conditioning at acceptance (optional subtract: invert B, carry 1).
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
`endif
  end

  // Slice arithmetic and the shifted-in sum for the current RUN cycle.
  always_comb begin
    slice_s  = slice_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
    digit_s  = slice_s[DIGIT-1:0];
    cy_s     = slice_s[DIGIT];
    cmsb_s   = msb_carry_in(a_r[DIGIT-1], b_r[DIGIT-1], digit_s[DIGIT-1]);
    sum_nx_s = (sum_r >> DIGIT) | (WIDTH'(digit_s) << (WIDTH - DIGIT));
    last_s   = (cnt_r == CW'(LAST));
  end

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register plus registered handshake flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      in_ready_r  <= (state_nx == ST_IDLE);
      out_valid_r <= (state_nx == ST_DONE);
    end
  end

  // Datapath: latch operands on acceptance, shift one digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      c_r     <= 1'b0;
      ovf_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b_load_s;
            carry_r <= carry_load_s;
            cnt_r   <= '0;
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          sum_r   <= sum_nx_s;
          carry_r <= cy_s;
          if (last_s) begin
            c_r   <= cy_s;
            ovf_r <= cmsb_s ^ cy_s;
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          // Result held for as long as the consumer stalls.
        end
        default: begin
          // Unreachable encodings hold the datapath; the FSM recovers to IDLE.
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = sum_r;
  assign c         = c_r;
  assign ovf       = ovf_r;

endmodule
